// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder.
// Holds the MMIO window default base, the MMIO register offsets and the byte-merge helper
// used by both the RAM write path and the MMIO register write path.
package data_sram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hbfaf_0000;

  // Byte offsets inside the MMIO window (bits [1:0] are never decoded).
  localparam logic [15:0] LED_OFF   = 16'h0000;
  localparam logic [15:0] SW_OFF    = 16'h0004;
  localparam logic [15:0] TIMER_OFF = 16'h0008;
  localparam logic [15:0] NUM_OFF   = 16'h000c;

  // Replace each byte of old_word whose enable bit is set with the matching byte of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data SRAM bus between the core (master) and the responder (slave).
//   data_sram_en    : access request this cycle
//   data_sram_wen   : byte write enables, 4'b0000 with en means read
//   data_sram_addr  : byte address, bits [1:0] ignored
//   data_sram_wdata : write data
//   data_sram_rdata : read data, valid the cycle after an en cycle
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder_sram_bytewen_ram.sv
// Single-port 2**AddrW x 32 RAM with per-byte write enables and a read-first registered output.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (clears the output register only)
//   en_i    : access this cycle
//   wen_i   : byte write enables
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : old word at addr_i from the last en cycle, held otherwise
module sram_bytewen_ram
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned AddrW = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [3:0]       wen_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Storage is not reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk_i) begin
    if (rst_ni && en_i && (wen_i != 4'b0000)) begin
      mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, wen_i);
    end
  end

  // Captures the pre-write word, giving read-first behaviour on write cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Target side of the CPU data SRAM port: decodes each access to an internal byte-writable RAM
// or to a small MMIO window (LED, switch, free-running timer, seg-display number), returning
// read data with one cycle of latency.
//   clk       : system clock
//   resetn    : asynchronous active-low reset
//   sram      : data SRAM bus, slave side
//   switch_in : board switch levels, sampled on read
//   led_out   : LED register contents
//   num_out   : seg-display number register contents
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter logic [31:0] TIMER_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_sram_responder_if.slave  sram,
  input  logic [15:0]           switch_in,
  output logic [15:0]           led_out,
  output logic [31:0]           num_out
);

  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        mmio_hit;
  logic        ram_en;
  logic        mmio_en;
  logic [13:0] mmio_word_off;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_rdata;
  logic [1:0]  unused_addr_lsb;

  logic [15:0] led_d, led_q;
  logic [31:0] num_d, num_q;
  logic [31:0] timer_d, timer_q;
  logic [31:0] mmio_rdata_d, mmio_rdata_q;
  logic        hit_d, hit_q;
  logic [31:0] mmio_word;

  assign en    = sram.data_sram_en;
  assign wen   = sram.data_sram_wen;
  assign addr  = sram.data_sram_addr;
  assign wdata = sram.data_sram_wdata;
  assign wr    = (wen != 4'b0000);

  assign unused_addr_lsb = addr[1:0];

  assign mmio_hit      = (addr[31:16] == MMIO_BASE[31:16]);
  assign ram_en        = en && !mmio_hit;
  assign mmio_en       = en && mmio_hit;
  assign mmio_word_off = addr[15:2];
  // Upper address bits are dropped, so RAM aliases across the non-MMIO space.
  assign ram_addr      = addr[ADDR_W+1:2];

  sram_bytewen_ram #(
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .en_i    (ram_en),
    .wen_i   (wen),
    .addr_i  (ram_addr),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    led_d        = led_q;
    num_d        = num_q;
    timer_d      = timer_q + 32'd1;
    mmio_rdata_d = mmio_rdata_q;
    hit_d        = hit_q;
    mmio_word    = '0;

    if (en) hit_d = mmio_hit;

    if (mmio_en) begin
      case (mmio_word_off)
        LED_OFF[15:2]: begin
          mmio_word = {16'h0000, led_q};
          // Only lanes 0-1 exist in the LED register.
          if (wen[0]) led_d[7:0]  = wdata[7:0];
          if (wen[1]) led_d[15:8] = wdata[15:8];
        end
        SW_OFF[15:2]: begin
          mmio_word = {16'h0000, switch_in};
        end
        TIMER_OFF[15:2]: begin
          mmio_word = timer_q;
          // A write loads the merged value in place of this cycle's increment.
          if (wr) timer_d = byte_merge(timer_q, wdata, wen);
        end
        NUM_OFF[15:2]: begin
          mmio_word = num_q;
          num_d     = byte_merge(num_q, wdata, wen);
        end
        default: begin
          mmio_word = '0;
        end
      endcase
      mmio_rdata_d = mmio_word;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q        <= '0;
      num_q        <= '0;
      timer_q      <= TIMER_RST;
      mmio_rdata_q <= '0;
      hit_q        <= 1'b0;
    end else begin
      led_q        <= led_d;
      num_q        <= num_d;
      timer_q      <= timer_d;
      mmio_rdata_q <= mmio_rdata_d;
      hit_q        <= hit_d;
    end
  end

  // Both sources are registers and hit_q only moves on en cycles, so rdata holds when idle.
  assign sram.data_sram_rdata = hit_q ? mmio_rdata_q : ram_rdata;
  assign led_out              = led_q;
  assign num_out              = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam logic [31:0] MMIO = 32'hbfaf_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] switch_in = 16'h0000;
  logic [15:0] led_out;
  logic [31:0] num_out;

  data_sram_responder_if bus ();

  data_sram_responder dut (
    .clk       (clk),
    .resetn    (resetn),
    .sram      (bus),
    .switch_in (switch_in),
    .led_out   (led_out),
    .num_out   (num_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] ram_m [int];
  logic [15:0] led_m = 16'h0;
  logic [31:0] num_m = 32'h0;
  logic [31:0] timer_m = 32'h0;
  logic [31:0] rdata_m = 32'h0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == MMIO[31:16];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a[17:2]);
    if (is_mmio(a)) begin
      case (a[15:2])
        14'h0:   return {16'h0, led_m};
        14'h1:   return {16'h0, switch_in};
        14'h2:   return timer_m;
        14'h3:   return num_m;
        default: return 32'h0;
      endcase
    end
    if (ram_m.exists(idx)) return ram_m[idx];
    return 32'hxxxx_xxxx;
  endfunction

  // One clock cycle: apply inputs, advance the model, return #1 after the rising edge.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] a,
                      input logic [31:0] wd);
    bit          timer_loaded;
    int          idx;
    logic [31:0] tmp;
    timer_loaded = 1'b0;
    idx = int'(a[17:2]);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = a;
    bus.data_sram_wdata = wd;
    if (en) begin
      rdata_m = model_read(a);
      if (wen != 4'b0000) begin
        if (is_mmio(a)) begin
          case (a[15:2])
            14'h0: begin
              tmp = merge({16'h0, led_m}, wd, wen);
              led_m = tmp[15:0];
            end
            14'h2: begin
              timer_m = merge(timer_m, wd, wen);
              timer_loaded = 1'b1;
            end
            14'h3: num_m = merge(num_m, wd, wen);
            default: ;
          endcase
        end else begin
          tmp = ram_m.exists(idx) ? ram_m[idx] : 32'hxxxx_xxxx;
          ram_m[idx] = merge(tmp, wd, wen);
        end
      end
    end
    if (!timer_loaded) timer_m = timer_m + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.data_sram_en = 1'b0;
    bus.data_sram_wen = 4'h0;
    bus.data_sram_addr = 32'h0;
    bus.data_sram_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    led_m = 16'h0;
    num_m = 32'h0;
    timer_m = 32'h0;
    rdata_m = 32'h0;
    checks++;
    if (bus.data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected %h", bus.data_sram_rdata, 32'h0);
    end
    checks++;
    if (led_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_led: got %h expected %h", led_out, 16'h0);
    end
    checks++;
    if (num_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_num: got %h expected %h", num_out, 32'h0);
    end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, MMIO + 32'h8, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'h2 || rdata_m !== 32'h2) begin
      errors++;
      $display("FAIL reset_timer: got %h expected %h", bus.data_sram_rdata, 32'h2);
    end
  endtask

  task automatic test_ram_byte();
    step(1'b1, 4'b1111, 32'h0000_0100, 32'h1122_3344);
    step(1'b1, 4'b0101, 32'h0000_0100, 32'haabb_ccdd);
    checks++;
    if (bus.data_sram_rdata !== 32'h1122_3344) begin
      errors++;
      $display("FAIL ram_write_old: got %h expected %h", bus.data_sram_rdata, 32'h1122_3344);
    end
    step(1'b1, 4'b0000, 32'h0000_0100, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'h11bb_33dd || rdata_m !== 32'h11bb_33dd) begin
      errors++;
      $display("FAIL ram_byte: got %h expected %h", bus.data_sram_rdata, 32'h11bb_33dd);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 4'b1111, 32'h0000_0200, 32'hdead_beef);
    step(1'b1, 4'b0000, 32'h0000_0200, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'hdead_beef) begin
      errors++;
      $display("FAIL b2b_read: got %h expected %h", bus.data_sram_rdata, 32'hdead_beef);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 32'h0000_0200, 32'h0bad_0bad);
      checks++;
      if (bus.data_sram_rdata !== 32'hdead_beef) begin
        errors++;
        $display("FAIL hold_%0d: got %h expected %h", i, bus.data_sram_rdata, 32'hdead_beef);
      end
    end
  endtask

  task automatic test_mmio();
    step(1'b1, 4'b1111, MMIO + 32'h0, 32'hffff_1234);
    checks++;
    if (led_out !== 16'h1234) begin
      errors++;
      $display("FAIL led_write: got %h expected %h", led_out, 16'h1234);
    end
    step(1'b1, 4'b0000, MMIO + 32'h0, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL led_read: got %h expected %h", bus.data_sram_rdata, 32'h0000_1234);
    end
    step(1'b1, 4'b1111, MMIO + 32'hc, 32'h0000_5678);
    checks++;
    if (num_out !== 32'h0000_5678) begin
      errors++;
      $display("FAIL num_write: got %h expected %h", num_out, 32'h0000_5678);
    end
    switch_in = 16'ha5a5;
    step(1'b1, 4'b0000, MMIO + 32'h4, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'h0000_a5a5) begin
      errors++;
      $display("FAIL switch_read: got %h expected %h", bus.data_sram_rdata, 32'h0000_a5a5);
    end
    step(1'b1, 4'b0000, MMIO + 32'h10, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: got %h expected %h", bus.data_sram_rdata, 32'h0);
    end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] want [3];
    want[0] = 32'hffff_fffe;
    want[1] = 32'hffff_ffff;
    want[2] = 32'h0000_0000;
    step(1'b1, 4'b1111, MMIO + 32'h8, 32'hffff_fffe);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000, MMIO + 32'h8, 32'h0);
      checks++;
      if (bus.data_sram_rdata !== want[i] || rdata_m !== want[i]) begin
        errors++;
        $display("FAIL timer_wrap_%0d: got %h expected %h", i, bus.data_sram_rdata, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'b0000, 32'h0000_0200, 32'h0);
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_rdata: got %h expected %h", bus.data_sram_rdata, 32'h0);
    end
    checks++;
    if (led_out !== 16'h0 || num_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_regs: got %h/%h expected 0/0", led_out, num_out);
    end
    led_m = 16'h0;
    num_m = 32'h0;
    timer_m = 32'h0;
    rdata_m = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h expected %h", bus.data_sram_rdata, 32'h0);
    end
    step(1'b1, 4'b0000, 32'h0000_0200, 32'h0);
    checks++;
    if (bus.data_sram_rdata !== 32'hdead_beef) begin
      errors++;
      $display("FAIL reset_mid_ram: got %h expected %h", bus.data_sram_rdata, 32'hdead_beef);
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [8];
    logic [15:0] offs [6];
    logic [31:0] a;
    logic [3:0]  be;
    int          kind;
    for (int i = 0; i < 8; i++) pool[i] = 16'(i * 4099 + 7);
    offs[0] = 16'h0000; offs[1] = 16'h0004; offs[2] = 16'h0008;
    offs[3] = 16'h000c; offs[4] = 16'h0010; offs[5] = 16'hff00;
    // Fill the pool so later partial writes and reads have a defined old value.
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, {14'h0, pool[i], 2'b00}, $urandom);
    for (int n = 0; n < 300; n++) begin
      switch_in = 16'($urandom);
      kind = $urandom_range(0, 9);
      be = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if (kind < 6) begin
        a = {14'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], 2'($urandom)};
      end else begin
        a = MMIO | {16'h0, offs[$urandom_range(0, 5)]} | {30'h0, 2'($urandom)};
      end
      step(kind >= 2, be, a, $urandom);
      checks++;
      if (bus.data_sram_rdata !== rdata_m) begin
        errors++;
        $display("FAIL rand_rdata_%0d: addr %h got %h expected %h", n, a,
                 bus.data_sram_rdata, rdata_m);
      end
      checks++;
      if (led_out !== led_m) begin
        errors++;
        $display("FAIL rand_led_%0d: got %h expected %h", n, led_out, led_m);
      end
      checks++;
      if (num_out !== num_m) begin
        errors++;
        $display("FAIL rand_num_%0d: got %h expected %h", n, num_out, num_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_byte();
    test_back_to_back();
    test_mmio();
    test_timer_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
